// File: rtl/rpsc_power_sequencer.sv
// Fan and cathode-supply power sequencer for one RPSC card.
// Brings the chain up in order (fan, settle, CA supply, CA delay, run),
// shuts it down through a fan cooldown, and latches the first fault
// until an operator clear with the interlocks healthy.
module rpsc_power_sequencer #(
  parameter int FAN_ACK_TIMEOUT  = 512,
  parameter int FAN_SETTLE_TICKS = 256,
  parameter int CA_ACK_TIMEOUT   = 512,
  parameter int CA_DELAY_TICKS   = 3840,
  parameter int COOL_TICKS       = 3840,
  parameter int CNT_W            = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_clear,
  input  logic       interlock_ok,
  input  logic       g1_ok,
  input  logic       fan_act,
  input  logic       ca_ps_act,
  output logic       fan_on,
  output logic       ca_on_perm,
  output logic       ca_on,
  output logic       ca_ok,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FAN_WAIT   = 3'd1,
    S_FAN_SETTLE = 3'd2,
    S_CA_WAIT    = 3'd3,
    S_CA_DELAY   = 3'd4,
    S_RUN        = 3'd5,
    S_COOLDOWN   = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  // Terminal timer values: a state of N ticks leaves when timer == N-1.
  localparam logic [CNT_W-1:0] FAN_TO_LAST = CNT_W'(FAN_ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(FAN_SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CA_TO_LAST  = CNT_W'(CA_ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(CA_DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOL_TICKS - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] timer;
  logic [2:0]       det;

  assign state_o = state;

  // Fault detection; the lowest-numbered active cause wins.
  always_comb begin
    det = 3'd0;
    if ((state inside {S_FAN_WAIT, S_FAN_SETTLE, S_CA_WAIT, S_CA_DELAY,
                       S_RUN, S_COOLDOWN}) && !interlock_ok)
      det = 3'd1;
    else if (state == S_FAN_WAIT && !fan_act && timer == FAN_TO_LAST)
      det = 3'd2;
    else if ((state inside {S_FAN_SETTLE, S_CA_WAIT, S_CA_DELAY, S_RUN}) && !fan_act)
      det = 3'd3;
    else if (state == S_CA_WAIT && !ca_ps_act && timer == CA_TO_LAST)
      det = 3'd4;
    else if ((state inside {S_CA_DELAY, S_RUN}) && !ca_ps_act)
      det = 3'd5;
    else if ((state inside {S_CA_WAIT, S_CA_DELAY, S_RUN}) && !g1_ok)
      det = 3'd6;
  end

  // Next-state selection: fault first, then stop, then the normal sequence.
  always_comb begin
    nxt = state;
    if (det != 3'd0) begin
      nxt = S_FAULT;
    end else begin
      case (state)
        S_IDLE:       if (start && !stop) nxt = S_FAN_WAIT;
        S_FAN_WAIT:   if (stop) nxt = S_COOLDOWN;
                      else if (fan_act) nxt = S_FAN_SETTLE;
        S_FAN_SETTLE: if (stop) nxt = S_COOLDOWN;
                      else if (timer == SETTLE_LAST) nxt = S_CA_WAIT;
        S_CA_WAIT:    if (stop) nxt = S_COOLDOWN;
                      else if (ca_ps_act) nxt = S_CA_DELAY;
        S_CA_DELAY:   if (stop) nxt = S_COOLDOWN;
                      else if (timer == DELAY_LAST) nxt = S_RUN;
        S_RUN:        if (stop) nxt = S_COOLDOWN;
        S_COOLDOWN:   if (timer == COOL_LAST) nxt = S_IDLE;
        S_FAULT:      if (fault_clear && interlock_ok) nxt = S_IDLE;
        default:      nxt = S_IDLE;
      endcase
    end
  end

  // State, timer, latched fault cause and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      fault_code <= 3'd0;
      fan_on     <= 1'b0;
      ca_on_perm <= 1'b0;
      ca_on      <= 1'b0;
      ca_ok      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (nxt != state) ? '0 : timer + CNT_W'(1);
      if (nxt == S_FAULT && state != S_FAULT)
        fault_code <= det;
      else if (state == S_FAULT && nxt == S_IDLE)
        fault_code <= 3'd0;
      fan_on     <= nxt inside {S_FAN_WAIT, S_FAN_SETTLE, S_CA_WAIT,
                                S_CA_DELAY, S_RUN, S_COOLDOWN};
      ca_on_perm <= nxt inside {S_CA_WAIT, S_CA_DELAY, S_RUN};
      ca_on      <= nxt inside {S_CA_WAIT, S_CA_DELAY, S_RUN};
      ca_ok      <= (nxt == S_RUN);
      fault      <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// Scoreboard bench for rpsc_power_sequencer: directed sequences plus a
// randomized soak, each cycle predicted by a rule-level reference model.
module tb_rpsc_power_sequencer;

  localparam int FAT = 5;
  localparam int FST = 8;
  localparam int CAT = 6;
  localparam int CDT = 16;
  localparam int CT  = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       fault_clear;
  logic       interlock_ok;
  logic       g1_ok;
  logic       fan_act;
  logic       ca_ps_act;
  logic       fan_on;
  logic       ca_on_perm;
  logic       ca_on;
  logic       ca_ok;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] state_o;

  rpsc_power_sequencer #(
    .FAN_ACK_TIMEOUT (FAT),
    .FAN_SETTLE_TICKS(FST),
    .CA_ACK_TIMEOUT  (CAT),
    .CA_DELAY_TICKS  (CDT),
    .COOL_TICKS      (CT),
    .CNT_W           (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .fault_clear (fault_clear),
    .interlock_ok(interlock_ok),
    .g1_ok       (g1_ok),
    .fan_act     (fan_act),
    .ca_ps_act   (ca_ps_act),
    .fan_on      (fan_on),
    .ca_on_perm  (ca_on_perm),
    .ca_on       (ca_on),
    .ca_ok       (ca_ok),
    .fault       (fault),
    .fault_code  (fault_code),
    .state_o     (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic [10:0] q[$];

  // Reference model: phase number, cycles spent in phase, latched cause.
  int m_ph   = 0;
  int m_t    = 0;
  int m_code = 0;

  function automatic int dwell(input int ph);
    case (ph)
      2:       return FST;
      4:       return CDT;
      6:       return CT;
      default: return 0;
    endcase
  endfunction

  function automatic logic [10:0] expected();
    logic [2:0] ph3;
    logic [2:0] c3;
    ph3 = 3'(m_ph);
    c3  = 3'(m_code);
    return {ph3, c3, (m_ph >= 1 && m_ph <= 6), (m_ph >= 3 && m_ph <= 5),
            (m_ph >= 3 && m_ph <= 5), (m_ph == 5), (m_ph == 7)};
  endfunction

  function automatic void model_step();
    bit [6:1] hit;
    int fc;
    int nph;
    if (!reset) begin
      m_ph = 0; m_t = 0; m_code = 0;
      return;
    end
    hit[1] = (m_ph >= 1 && m_ph <= 6) && !interlock_ok;
    hit[2] = (m_ph == 1) && !fan_act && (m_t == FAT - 1);
    hit[3] = (m_ph >= 2 && m_ph <= 5) && !fan_act;
    hit[4] = (m_ph == 3) && !ca_ps_act && (m_t == CAT - 1);
    hit[5] = (m_ph == 4 || m_ph == 5) && !ca_ps_act;
    hit[6] = (m_ph >= 3 && m_ph <= 5) && !g1_ok;
    fc = 0;
    for (int c = 1; c <= 6; c++)
      if (hit[c] && fc == 0) fc = c;
    nph = m_ph;
    if (fc != 0) begin
      nph = 7; m_code = fc;
    end else if (m_ph == 0) begin
      if (start && !stop) nph = 1;
    end else if (m_ph >= 1 && m_ph <= 5 && stop) begin
      nph = 6;
    end else if (m_ph == 1 && fan_act) begin
      nph = 2;
    end else if (m_ph == 3 && ca_ps_act) begin
      nph = 4;
    end else if (dwell(m_ph) > 0 && m_t == dwell(m_ph) - 1) begin
      nph = (m_ph == 6) ? 0 : m_ph + 1;
    end else if (m_ph == 7 && fault_clear && interlock_ok) begin
      nph = 0; m_code = 0;
    end
    m_t  = (nph != m_ph) ? 0 : m_t + 1;
    m_ph = nph;
  endfunction

  // Predict the coming edge from the inputs now applied, then move on.
  task automatic tick();
    model_step();
    q.push_back(expected());
    @(negedge clk);
    #1;
  endtask

  task automatic guard_check(input string name, input int guard, input int lim);
    total++;
    if (guard >= lim) begin
      bad++;
      $display("FAIL %s bound: spent %0d cycles, allowed below %0d", name, guard, lim);
    end
  endtask

  task automatic bring_up(input int target);
    int guard;
    guard = 0;
    while (m_ph != target && guard < 200) begin
      start     = (m_ph == 0);
      fan_act   = (m_ph >= 1 && m_ph <= 6);
      ca_ps_act = (m_ph >= 3 && m_ph <= 5);
      tick();
      guard++;
    end
    start = 1'b0;
    guard_check("bring_up", guard, 200);
  endtask

  task automatic wait_phase(input int target);
    int guard;
    guard = 0;
    while (m_ph != target && guard < 200) begin
      tick();
      guard++;
    end
    guard_check("wait_phase", guard, 200);
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic mid_reset();
    logic [10:0] act;
    reset = 1'b0;
    #1;
    act = {state_o, fault_code, fan_on, ca_on_perm, ca_on, ca_ok, fault};
    total++;
    if (act !== 11'd0) begin
      bad++;
      $display("FAIL async_reset: outputs %b, required all zero", act);
    end
    tick();
    tick();
  endtask

  // Monitor: each negedge, compare DUT outputs against the oldest prediction.
  initial begin
    logic [10:0] exp_v;
    logic [10:0] act_v;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_v = q.pop_front();
        act_v = {state_o, fault_code, fan_on, ca_on_perm, ca_on, ca_ok, fault};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL outputs at %0t: got st=%0d code=%0d fan/perm/ca/ok/flt=%b want st=%0d code=%0d fan/perm/ca/ok/flt=%b",
                   $time, act_v[10:8], act_v[7:5], act_v[4:0],
                   exp_v[10:8], exp_v[7:5], exp_v[4:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fan_hist;
    logic [3:0] ca_hist;
    fan_hist = '0;
    ca_hist  = '0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; fault_clear = 1'b0;
    interlock_ok = 1'b1; g1_ok = 1'b1; fan_act = 1'b0; ca_ps_act = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Nominal power-up with fan feedback 3 cycles after start.
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    fan_act = 1'b1; tick();
    wait_phase(3);
    tick(); tick();
    ca_ps_act = 1'b1;
    wait_phase(5);
    tick(); tick(); tick();

    // Orderly stop from RUN through the fan cooldown.
    stop = 1'b1; tick();
    stop = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Fan acknowledge timeout, then clear.
    fan_act = 1'b0; ca_ps_act = 1'b0;
    start = 1'b1; tick();
    start = 1'b0;
    wait_phase(7);
    tick();
    fault_clear = 1'b1; tick();
    fault_clear = 1'b0; tick();

    // Simultaneous interlock, CA loss and stop in RUN.
    bring_up(5);
    tick();
    interlock_ok = 1'b0; ca_ps_act = 1'b0; stop = 1'b1; tick();
    stop = 1'b0; fault_clear = 1'b1; tick(); tick();
    fault_clear = 1'b0; interlock_ok = 1'b1; tick();
    fault_clear = 1'b1; tick();
    fault_clear = 1'b0; tick();

    // Grid fault in CA_DELAY; the same in FAN_SETTLE is harmless.
    bring_up(4);
    g1_ok = 1'b0; tick();
    g1_ok = 1'b1; tick();
    fault_clear = 1'b1; tick();
    fault_clear = 1'b0; tick();
    bring_up(2);
    g1_ok = 1'b0; tick(); tick(); tick();
    g1_ok = 1'b1; stop = 1'b1; tick();
    stop = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset mid-sequence; stale fan feedback must not restart the chain.
    bring_up(4);
    tick(); tick();
    mid_reset();
    fan_act = 1'b1; ca_ps_act = 1'b0; reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    stop = 1'b1; tick();
    stop = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Randomized soak with a lagging fan/CA plant.
    for (int n = 0; n < 3000; n++) begin
      start        = ($urandom % 8) == 0;
      stop         = ($urandom % 200) == 0;
      fault_clear  = ($urandom % 10) == 0;
      interlock_ok = ($urandom % 300) != 0;
      g1_ok        = ($urandom % 300) != 0;
      fan_hist     = {fan_hist[2:0], (m_ph >= 1 && m_ph <= 6)};
      ca_hist      = {ca_hist[2:0], (m_ph >= 3 && m_ph <= 5)};
      fan_act      = fan_hist[$urandom_range(0, 2)] && (($urandom % 500) != 0);
      ca_ps_act    = ca_hist[$urandom_range(0, 2)] && (($urandom % 500) != 0);
      if (($urandom % 1500) == 0) begin
        mid_reset();
        reset = 1'b1;
      end
      tick();
    end

    stop = 1'b0; start = 1'b0;
    @(negedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
